// File: rtl/slot_buffer.sv
// Per-port compacted packet slot FIFO: pushes fill the lowest free slot and slot 0
// drains through a ready/valid port that waits a minimum gap between pops.
module slot_buffer #(
   parameter int SLOTS     = 6,
   parameter int DRAIN_GAP = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   input  logic [1:0]                   in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [1:0]                   out_data,
   input  logic                         out_ready,
   output logic [3*SLOTS-1:0]           buffer_o,
   output logic [$clog2(SLOTS+1)-1:0]   level
);

   localparam int LW = $clog2(SLOTS + 1);
   localparam int TW = $clog2(DRAIN_GAP + 1);
   localparam int BW = 3 * SLOTS;

   typedef enum logic [1:0] {EMPTY, OFFER, GAP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   buf_q, buf_d;
   logic [LW-1:0]   level_q, level_d;
   logic [LW-1:0]   wr_idx;
   logic [TW-1:0]   timer_q, timer_d;
   logic            full, push, pop;

   assign full      = (level_q == LW'(SLOTS));
   assign out_valid = (state_q == OFFER);
   assign out_data  = buf_q[2:1];
   assign pop       = out_valid && out_ready;
   // A full buffer still accepts when slot 0 leaves in the same cycle.
   assign in_ready  = !full || pop;
   assign push      = in_valid && in_ready;
   assign buffer_o  = buf_q;
   assign level     = level_q;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      buf_d   = buf_q;
      wr_idx  = pop ? level_q - LW'(1) : level_q;
      level_d = level_q + LW'(push) - LW'(pop);
      if (pop) begin
         buf_d = {3'b000, buf_q[BW-1:3]};
      end
      if (push) begin
         for (int k = 0; k < SLOTS; k++) begin
            if (LW'(k) == wr_idx) begin
               buf_d[3*k +: 3] = {in_data, 1'b1};
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         EMPTY: begin
            if (push) state_d = OFFER;
         end
         OFFER: begin
            if (pop) begin
               if (level_q == LW'(1) && !push) begin
                  state_d = EMPTY;
               end else if (DRAIN_GAP > 1) begin
                  state_d = GAP;
                  timer_d = TW'(DRAIN_GAP - 1);
               end
            end
         end
         GAP: begin
            if (timer_q == TW'(1)) begin
               state_d = (level_d != '0) ? OFFER : EMPTY;
               timer_d = '0;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         buf_q   <= '0;
         level_q <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         level_q <= level_d;
         timer_q <= timer_d;
      end
   end

endmodule

// File: tb/tb_slot_buffer.sv
// Self-checking bench for slot_buffer: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_slot_buffer;

   localparam int SLOTS     = 6;
   localparam int DRAIN_GAP = 4;
   localparam int LW        = $clog2(SLOTS + 1);
   localparam int BW        = 3 * SLOTS;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic [1:0]      in_data = 2'd0;
   logic            in_ready;
   logic            out_valid;
   logic [1:0]      out_data;
   logic            out_ready = 1'b0;
   logic [BW-1:0]   buffer_o;
   logic [LW-1:0]   level;

   int n_checks = 0;
   int n_fail   = 0;

   slot_buffer #(.SLOTS(SLOTS), .DRAIN_GAP(DRAIN_GAP)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .buffer_o(buffer_o), .level(level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_data = 2'd0; out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push(input logic [1:0] d);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; out_ready = 1'b0;
   endtask

   typedef struct {
      logic        iv;
      logic [1:0]  d;
      logic        ordy;
      int          exp_level;
      logic        exp_valid;
      logic [1:0]  exp_data;
      logic        exp_ready;
   } vec_t;

   vec_t vecs[11];

   // Reference model: ordered payload queue plus the cycle of the last pop.
   logic [1:0] q[$];
   int         last_pop;
   bit         gap_waived;

   function automatic logic [BW-1:0] model_buffer();
      logic [BW-1:0] b = '0;
      for (int k = 0; k < q.size(); k++) b[3*k +: 3] = {q[k], 1'b1};
      return b;
   endfunction

   initial begin
      logic [15:0] pulse_mask;
      logic [5:0]  got_data;
      logic        exp_valid, exp_ready, do_pop, do_push;
      int          ready_pct;

      // Directed table: inputs held for one cycle; expectations sampled before the edge.
      vecs[0]  = '{1'b1, 2'd1, 1'b0, 0, 1'b0, 2'd0, 1'b1};
      vecs[1]  = '{1'b1, 2'd2, 1'b0, 1, 1'b1, 2'd1, 1'b1};
      vecs[2]  = '{1'b1, 2'd3, 1'b0, 2, 1'b1, 2'd1, 1'b1};
      vecs[3]  = '{1'b0, 2'd0, 1'b0, 3, 1'b1, 2'd1, 1'b1};
      vecs[4]  = '{1'b1, 2'd0, 1'b0, 3, 1'b1, 2'd1, 1'b1};
      vecs[5]  = '{1'b1, 2'd1, 1'b0, 4, 1'b1, 2'd1, 1'b1};
      vecs[6]  = '{1'b1, 2'd2, 1'b0, 5, 1'b1, 2'd1, 1'b1};
      vecs[7]  = '{1'b1, 2'd3, 1'b0, 6, 1'b1, 2'd1, 1'b0};
      vecs[8]  = '{1'b0, 2'd0, 1'b0, 6, 1'b1, 2'd1, 1'b0};
      vecs[9]  = '{1'b1, 2'd2, 1'b1, 6, 1'b1, 2'd1, 1'b1};
      vecs[10] = '{1'b0, 2'd0, 1'b0, 6, 1'b0, 2'd2, 1'b0};

      #2;
      check("reset_buffer", 32'(buffer_o), 32'd0);
      check("reset_level", 32'(level), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
         #1;
         check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
         if (i == 3)  check("three_push_buffer", 32'(buffer_o), 32'(18'b000_000_000_111_101_011));
         if (i == 8)  check("full_blocked_buffer", 32'(buffer_o), 32'(18'b101_011_001_111_101_011));
         if (i == 10) check("full_push_pop_buffer", 32'(buffer_o), 32'(18'b101_101_011_001_111_101));
      end

      // Three entries drained with out_ready held high: pulses spaced DRAIN_GAP apart.
      do_reset();
      push(2'd1); push(2'd2); push(2'd3);
      pulse_mask = '0; got_data = '0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         #1;
         pulse_mask[c] = out_valid;
         if (out_valid) got_data = {got_data[3:0], out_data};
      end
      check("gap_pulse_pattern", 32'(pulse_mask), 32'(16'b0000_0001_0001_0001));
      check("gap_drain_order", 32'(got_data), 32'(6'b01_10_11));
      check("gap_final_level", 32'(level), 32'd0);

      // Single push with consumer ready: one-cycle latency, then empty.
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; in_data = 2'd2; out_ready = 1'b1;
      #1;
      check("single_pre_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_data", 32'(out_data), 32'd2);
      @(negedge clk);
      #1;
      check("single_after_valid", 32'(out_valid), 32'd0);
      check("single_after_level", 32'(level), 32'd0);
      check("single_after_buffer", 32'(buffer_o), 32'd0);

      // Asynchronous reset while waiting out a drain gap with four entries.
      do_reset();
      push(2'd1); push(2'd2); push(2'd3); push(2'd0); push(2'd1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check("midgap_level", 32'(level), 32'd4);
      check("midgap_out_valid", 32'(out_valid), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_buffer", 32'(buffer_o), 32'd0);
      check("async_reset_level", 32'(level), 32'd0);
      check("async_reset_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the queue model.
      q.delete();
      last_pop = -1000;
      gap_waived = 1'b1;
      for (int c = 0; c < 800; c++) begin
         ready_pct = ((c / 100) % 2 == 0) ? 15 : 80;
         @(negedge clk);
         in_valid  = ($urandom_range(0, 99) < 65);
         in_data   = 2'($urandom);
         out_ready = ($urandom_range(0, 99) < ready_pct);
         #1;
         exp_valid = (q.size() > 0) && (gap_waived || c >= last_pop + DRAIN_GAP);
         do_pop    = exp_valid && out_ready;
         exp_ready = (q.size() < SLOTS) || do_pop;
         do_push   = in_valid && exp_ready;
         check("rand_out_valid", 32'(out_valid), 32'(exp_valid));
         check("rand_in_ready", 32'(in_ready), 32'(exp_ready));
         check("rand_level", 32'(level), 32'(q.size()));
         check("rand_buffer", 32'(buffer_o), 32'(model_buffer()));
         if (exp_valid) check("rand_out_data", 32'(out_data), 32'(q[0]));
         if (do_pop) begin
            void'(q.pop_front());
            last_pop   = c;
            gap_waived = (q.size() == 0) && !do_push;
         end
         if (do_push) q.push_back(in_data);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
